// File: rtl/fetch_stage.sv
// RV64I instruction-fetch stage: owns the PC, runs the instruction-bus handshake
// and loads the IF/ID register (dataF) consumed by decode.
module fetch_stage #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic [96:0] dataF
);

  typedef enum logic [1:0] {
    FETCH,
    HOLD,
    DRAIN
  } state_t;

  localparam logic [96:0] BUBBLE = {32'h0, 64'h0, 1'b1};

  state_t      state;
  logic [63:0] pc;
  logic [63:0] pend_pc;
  logic [31:0] hold_word;
  logic [63:0] target;
  logic        issue;
  logic [31:0] issue_word;

  assign target     = redirect_pc & ~64'h3;
  assign ireq_valid = !reset && (state != HOLD);
  assign ireq_addr  = pc;

  // An instruction leaves the stage only when neither a redirect nor a stall blocks it.
  always_comb begin
    issue      = 1'b0;
    issue_word = '0;
    case (state)
      FETCH: begin
        issue      = iresp_data_ok && !redirect_valid && !stall;
        issue_word = iresp_data;
      end
      HOLD: begin
        issue      = !redirect_valid && !stall;
        issue_word = hold_word;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc        <= RESET_PC;
      state     <= FETCH;
      pend_pc   <= '0;
      hold_word <= '0;
      dataF     <= BUBBLE;
    end else begin
      if (redirect_valid) begin
        dataF <= BUBBLE;
      end else if (!stall) begin
        dataF <= issue ? {issue_word, pc, 1'b0} : BUBBLE;
      end

      if (issue) begin
        pc <= pc + 64'd4;
      end

      // The bus address is pc, so pc only moves when the outstanding request completes.
      case (state)
        FETCH: begin
          if (iresp_data_ok) begin
            if (redirect_valid) begin
              pc <= target;
            end else if (stall) begin
              hold_word <= iresp_data;
              state     <= HOLD;
            end
          end else if (redirect_valid) begin
            pend_pc <= target;
            state   <= DRAIN;
          end
        end
        HOLD: begin
          if (redirect_valid) begin
            pc    <= target;
            state <= FETCH;
          end else if (!stall) begin
            state <= FETCH;
          end
        end
        DRAIN: begin
          if (iresp_data_ok) begin
            pc    <= redirect_valid ? target : pend_pc;
            state <= FETCH;
          end else if (redirect_valid) begin
            pend_pc <= target;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule
